// File: rtl/ex_stage.sv
// ARVI execute stage: single-cycle RV32I ALU plus an iterative
// RV32M multiply/divide unit that stalls the pipeline while busy.
module ex_stage #(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_flush,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_res,
    output logic            o_z,
    output logic            o_stall
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        mop_q, mop_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic [XLEN-1:0]   base;
    logic              is_m;
    logic              start;
    logic [2:0]        mop_in;
    logic              sa_in, sb_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              ge;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   res_fix;

    always_comb begin
        unique case (i_op)
            5'd0:    base = i_a + i_b;
            5'd1:    base = i_a - i_b;
            5'd2:    base = i_a << i_b[4:0];
            5'd3:    base = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            5'd4:    base = {{(XLEN-1){1'b0}}, i_a < i_b};
            5'd5:    base = i_a ^ i_b;
            5'd6:    base = i_a >> i_b[4:0];
            5'd7:    base = $signed(i_a) >>> i_b[4:0];
            5'd8:    base = i_a | i_b;
            5'd9:    base = i_a & i_b;
            default: base = '0;
        endcase
    end

    // Ops 10..17 map to 0..7 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
    assign is_m   = (i_op >= 5'd10) && (i_op <= 5'd17);
    assign mop_in = i_op[2:0] + 3'd6;
    assign sa_in  = i_a[XLEN-1] & (mop_in inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
    assign sb_in  = i_b[XLEN-1] & (mop_in inside {3'd0, 3'd1, 3'd4, 3'd6});
    assign a_mag  = sa_in ? -i_a : i_a;
    assign b_mag  = sb_in ? -i_b : i_b;
    assign start  = MULDIV_EN && i_valid && is_m && !i_flush && !i_rst;

    // Divide keeps {remainder, dividend/quotient} in acc; multiply sums into it
    always_comb begin
        ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
        diff = acc_q[2*XLEN-2:XLEN-1] - b_q;
        if (mop_q[2])
            acc_nx = {ge ? diff : acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], ge};
        else
            acc_nx = acc_q + (b_q[0] ? mcand_q : '0);
        prod = (sa_q ^ sb_q) ? -acc_nx : acc_nx;
        quo  = (sa_q ^ sb_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem  = sa_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        unique case (mop_q)
            3'd0:       res_fix = prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       res_fix = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5: res_fix = (b_q == '0) ? '1 : quo;
            default:    res_fix = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    mop_d   = mop_in;
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    b_d     = b_mag;
                    mcand_d = {{XLEN{1'b0}}, a_mag};
                    acc_d   = mop_in[2] ? {{XLEN{1'b0}}, a_mag} : '0;
                end
            end
            BUSY: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (!mop_q[2]) begin
                    mcand_d = mcand_q << 1;
                    b_d     = b_q >> 1;
                end
                if (cnt_q == '1) begin
                    state_d = DONE;
                    res_d   = res_fix;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush)
            state_d = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mop_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            mcand_q <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        o_stall = 1'b0;
        if (!i_rst && !i_flush) begin
            unique case (state_q)
                IDLE:    o_stall = start;
                BUSY:    o_stall = 1'b1;
                default: o_stall = 1'b0;
            endcase
        end
        if (i_flush || state_q == IDLE)
            o_res = base;
        else if (state_q == DONE)
            o_res = res_q;
        else
            o_res = '0;
    end

    assign o_z = (o_res == '0);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vectors, M-unit corner
// sequences and random ops against an arithmetic reference model.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        flush;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [31:0] res1, res2;
    logic        z1, z2, st1, st2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .MULDIV_EN(1'b1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flush(flush),
        .i_op(op), .i_a(a), .i_b(b),
        .o_res(res1), .o_z(z1), .o_stall(st1)
    );

    ex_stage #(.XLEN(32), .MULDIV_EN(1'b0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_flush(flush),
        .i_op(op), .i_a(a), .i_b(b),
        .o_res(res2), .o_z(z2), .o_stall(st2)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        int sx, sy;
        logic signed [63:0] p;
        logic [63:0] pu;
        sx = x;
        sy = y;
        case (o)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return x << y[4:0];
            5'd3:  return (sx < sy) ? 32'd1 : 32'd0;
            5'd4:  return (x < y) ? 32'd1 : 32'd0;
            5'd5:  return x ^ y;
            5'd6:  return x >> y[4:0];
            5'd7:  return sx >>> y[4:0];
            5'd8:  return x | y;
            5'd9:  return x & y;
            5'd10: begin p = 64'(sx) * 64'(sy); return p[31:0]; end
            5'd11: begin p = 64'(sx) * 64'(sy); return p[63:32]; end
            5'd12: begin
                p = 64'(sx) * $signed({32'b0, y});
                return p[63:32];
            end
            5'd13: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            5'd14: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return sx / sy;
            end
            5'd15: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd16: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
                return sx % sy;
            end
            5'd17: return (y == 0) ? x : x % y;
            default: return 0;
        endcase
    endfunction

    task automatic run_base(input logic [4:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp,
                            input string nm);
        op = o; a = x; b = y; valid = 1'b1;
        @(negedge clk);
        chk({nm, " res"}, res1, exp);
        chk({nm, " z"}, z1, exp == 0);
        chk({nm, " stall"}, st1, 0);
        chk({nm, " res md0"}, res2, exp);
        chk({nm, " stall md0"}, st2, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_m(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp,
                         input string nm);
        int n;
        logic s2;
        n = 0;
        s2 = 1'b0;
        op = o; a = x; b = y; valid = 1'b1;
        @(negedge clk);
        chk({nm, " res md0"}, res2, 0);
        while (st1 && n < 100) begin
            n++;
            s2 |= st2;
            @(posedge clk);
            @(negedge clk);
        end
        s2 |= st2;
        chk({nm, " stall cycles"}, n, 33);
        chk({nm, " res"}, res1, exp);
        chk({nm, " z"}, z1, exp == 0);
        chk({nm, " stall md0"}, s2, 0);
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        chk({nm, " idle stall"}, st1, 0);
        chk({nm, " idle res"}, res1, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp,
                          input string nm);
        if (o >= 10 && o <= 17)
            run_m(o, x, y, exp, nm);
        else
            run_base(o, x, y, exp, nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        vt.push_back('{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
        vt.push_back('{5'd1,  32'd5,         32'd5,         32'd0});
        vt.push_back('{5'd7,  32'h8000_0000, 32'd4,         32'hF800_0000});
        vt.push_back('{5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1});
        vt.push_back('{5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0});
        vt.push_back('{5'd2,  32'd1,         32'h21,        32'd2});
        vt.push_back('{5'd20, 32'h1234,      32'd5,         32'd0});
        vt.push_back('{5'd10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE});
        vt.push_back('{5'd11, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{5'd13, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001});
        vt.push_back('{5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        vt.push_back('{5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        vt.push_back('{5'd15, 32'd7,         32'd0,         32'hFFFF_FFFF});
        vt.push_back('{5'd17, 32'd7,         32'd0,         32'd7});
        vt.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vt.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
        vt.push_back('{5'd14, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF});
        vt.push_back('{5'd16, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9});
        vt.push_back('{5'd10, 32'd3,         32'd4,         32'd12});

        rst = 1'b1; flush = 1'b0; valid = 1'b1;
        op = 5'd10; a = 32'd3; b = 32'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall", st1, 0);
        chk("reset res", res1, 0);
        chk("reset z", z1, 1);
        valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i])
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp,
                   $sformatf("vec%0d", i));

        // flush mid-divide at BUSY count 10
        op = 5'd15; a = 32'd100; b = 32'd3; valid = 1'b1;
        @(negedge clk);
        chk("flush pre stall", st1, 1);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush stall", st1, 0);
        chk("flush res", res1, 0);
        chk("flush z", z1, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        op = 5'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        chk("post flush add", res1, 2);
        chk("post flush stall", st1, 0);
        @(posedge clk); #1;

        // asynchronous reset during a MULHSU
        op = 5'd12; a = 32'h1234_5678; b = 32'h9ABC_DEF0; valid = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre rst stall", st1, 1);
        #2 rst = 1'b1;
        #1;
        chk("async rst stall", st1, 0);
        chk("async rst res", res1, 0);
        @(negedge clk);
        chk("held rst stall", st1, 0);
        valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        run_m(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu rst");

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  ro;
            logic [31:0] rx, ry;
            ro = 5'($urandom_range(0, 31));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 0;
                1: ry = 32'($urandom_range(0, 9));
                2: rx = 32'h8000_0000;
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(ro, rx, ry, model(ro, rx, ry), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the ARVI datapath, directly upstream of the memory access stage.
- Computes the ALU result and zero flag consumed by memory access and branch control: load/store address, JALR target, branch compare result.
- Base RV32I ops are single-cycle combinational.
- RV32M ops use an iterative shift-add multiplier / restoring divider FSM and stall the pipeline until the result is ready.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- MULDIV_EN, 1, 1 instantiates the M-extension FSM; 0 makes every M op return 0 with no stall.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  the instruction in EX is real, not a bubble.
- i_flush  input  1  kill the current EX instruction (exception/redirect).
- i_op  input  5  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 reserved.
- i_a  input  XLEN  operand A, forwarded rs1 or PC.
- i_b  input  XLEN  operand B, forwarded rs2 or immediate.
- o_res  output  XLEN  result, feeds i_alu_res of the memory stage.
- o_z  output  1  o_res == 0, feeds i_z of the memory stage.
- o_stall  output  1  EX busy; upstream and the EX/MEM register must hold.

Behaviour:
- Base ops 0-9 (combinational, zero latency):
  - Shifts use i_b[4:0].
  - SLT/SLTU return 0 or 1.
  - o_stall stays 0.
- Reserved ops 18-31: o_res = 0, o_stall = 0.
- M ops 10-17 use FSM states IDLE, BUSY, DONE.
- IDLE:
  - Transition condition: i_valid & M op & !i_flush.
  - On that condition: o_stall = 1 combinationally; latch operand magnitudes, sign flags, op; count = 0; next state BUSY.
  - Signed ops: negate negative operands to their magnitude.
  - MULHSU: only A is treated as signed.
- BUSY:
  - One iteration per cycle: multiply adds a shifted multiplicand into a 64-bit accumulator; divide does a restoring subtract producing one quotient bit.
  - count increments each cycle; after count == 31, next state DONE.
  - o_stall = 1.
- DONE:
  - o_res = final result register; o_stall = 0, so the pipeline advances on this edge.
  - Next state IDLE unconditionally. The same op is still on the inputs but must not restart.
- Latency: o_stall is high for 33 cycles (the IDLE load cycle plus 32 BUSY cycles); the result is valid on the 34th cycle.
- Upstream holds i_op, i_a and i_b stable while o_stall = 1; the FSM uses latched copies only.
- Result selection and sign fix-up:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - Negate the 64-bit product when operand signs differ.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Divide by zero:
  - DIV/DIVU: quotient = 0xFFFFFFFF.
  - REM/REMU: result = i_a unchanged.
  - Still full latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- i_flush (any state):
  - o_stall = 0 in that cycle; next state IDLE.
  - Partial result discarded; o_res = combinational base result, or 0 for an M op.
- i_valid = 0 in IDLE: no M op starts; o_res still computed for observability.
- Reset (asynchronous, any state, including mid-operation):
  - State IDLE, count 0, accumulators and result register 0.
  - o_stall = 0 while i_rst is high.
- o_z always reflects the current o_res. In BUSY, o_res = 0, so o_z = 1; downstream ignores both while stalled.

Test Plan:
- ADD 0x7FFFFFFF + 1 -> o_res 0x80000000, o_z 0, o_stall 0. SUB 5 - 5 -> o_res 0, o_z 1. SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0xFFFFFFFF * 2 with i_valid -> o_stall high for exactly 33 cycles, then o_res 0xFFFFFFFE for one cycle, FSM back in IDLE. MULH same operands -> 0xFFFFFFFF. MULHU -> 0x00000001.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 7 / 0 -> 0xFFFFFFFF. REMU 7 / 0 -> 7. DIV 0x80000000 / -1 -> 0x80000000. REM of the same -> 0.
- Start DIVU 100 / 3; assert i_flush at BUSY count 10 -> o_stall 0 in that cycle, IDLE next. A following ADD 1 + 1 returns 2 with no stall.
- Start MULHSU; assert i_rst asynchronously mid-BUSY -> o_stall drops without a clock edge. After release, MULHSU 0xFFFFFFFF * 0xFFFFFFFF restarts from IDLE -> 0xFFFFFFFF after full latency.
- MULDIV_EN = 0: MUL 3 * 4 -> o_res 0, o_stall never asserted. Reserved op 20 -> o_res 0, o_z 1.
